// File: rtl/cnn_pkg.sv
// Shared sizes and FSM encoding for the convolution window sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cnn_pkg;

    localparam int DEF_IFM_SIZE     = 14;
    localparam int DEF_IFM_DEPTH    = 3;
    localparam int DEF_KERNAL_SIZE  = 5;
    localparam int DEF_ADDRESS_BITS = 15;

    // Output map edge length for a non-padded, stride-1 window.
    localparam int DEF_IFM_SIZE_NEXT = DEF_IFM_SIZE - DEF_KERNAL_SIZE + 1;

    // Line-buffer depth: K-1 full rows plus K taps of the current row.
    localparam int DEF_FIFO_SIZE = (DEF_KERNAL_SIZE - 1) * DEF_IFM_SIZE + DEF_KERNAL_SIZE;

    localparam int DEF_ADDRESS_SIZE_NEXT_IFM = $clog2(DEF_IFM_SIZE_NEXT * DEF_IFM_SIZE_NEXT);
    localparam int DEF_CH_BITS               = $clog2(DEF_IFM_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        TAIL   = 2'd2
    } state_t;

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Control, IFM read and window-qualifier bundle of the window sequencer.
// Latency: n/a (wires only). Ports: start/pause in; rd strobe/addr, fifo shift,
// window flags/addr/ch, busy/done out. Backpressure: pause gates new reads.
interface conv_window_ctrl_if
    import cnn_pkg::*;
#(
    parameter int ADDRESS_BITS   = DEF_ADDRESS_BITS,
    parameter int ADDR_NEXT_BITS = DEF_ADDRESS_SIZE_NEXT_IFM,
    parameter int CH_BITS        = DEF_CH_BITS
);
    logic                      start;
    logic                      pause;
    logic                      ifm_rd_en;
    logic [ADDRESS_BITS-1:0]   ifm_rd_addr;
    logic                      fifo_enable;
    logic                      window_valid;
    logic [ADDR_NEXT_BITS-1:0] window_addr;
    logic [CH_BITS-1:0]        window_ch;
    logic                      last_window;
    logic                      busy;
    logic                      done;

    modport master (
        input  start, pause,
        output ifm_rd_en, ifm_rd_addr, fifo_enable, window_valid,
               window_addr, window_ch, last_window, busy, done
    );

    modport slave (
        output start, pause,
        input  ifm_rd_en, ifm_rd_addr, fifo_enable, window_valid,
               window_addr, window_ch, last_window, busy, done
    );
endinterface

// File: rtl/conv_pos_counter.sv
// col/row/ch raster counter for the IFM read side; frame_last flags the final pixel.
// Latency: counters update on the edge ending an advance cycle; flags are combinational.
// Backpressure: holds its position whenever advance is low.
module conv_pos_counter
    import cnn_pkg::*;
#(
    parameter int SIZE     = DEF_IFM_SIZE,
    parameter int DEPTH    = DEF_IFM_DEPTH,
    parameter int POS_BITS = $clog2(DEF_IFM_SIZE),
    parameter int CH_BITS  = DEF_CH_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                advance,
    output logic [POS_BITS-1:0] col,
    output logic [POS_BITS-1:0] row,
    output logic [CH_BITS-1:0]  ch,
    output logic                frame_last
);
    localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(SIZE - 1);
    localparam logic [CH_BITS-1:0]  LAST_CH  = CH_BITS'(DEPTH - 1);

    logic col_last;
    logic row_last;
    logic ch_last;

    assign col_last   = (col == LAST_POS);
    assign row_last   = (row == LAST_POS);
    assign ch_last    = (ch == LAST_CH);
    assign frame_last = col_last && row_last && ch_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row <= '0;
                    // Wrapping after the final channel leaves the counter parked at 0.
                    ch  <= ch_last ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/conv_window_ctrl.sv
// Sequences IFM reads into the 5x5 line buffer and qualifies valid window cycles.
// Latency: read in cycle p, fifo_enable in p+1, window_valid in p+2; done one cycle after last_window.
// Backpressure: pause stalls new reads only; reads already issued drain through the pipeline.
module conv_window_ctrl
    import cnn_pkg::*;
#(
    parameter int IFM_SIZE     = DEF_IFM_SIZE,
    parameter int IFM_DEPTH    = DEF_IFM_DEPTH,
    parameter int KERNAL_SIZE  = DEF_KERNAL_SIZE,
    parameter int ADDRESS_BITS = DEF_ADDRESS_BITS
) (
    input  logic               clk,
    input  logic               reset,
    conv_window_ctrl_if.master bus
);
    localparam int IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1;
    localparam int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT);
    localparam int CH_BITS               = $clog2(IFM_DEPTH) + 1;
    localparam int POS_BITS              = $clog2(IFM_SIZE);

    localparam logic [POS_BITS-1:0]     K_M1       = POS_BITS'(KERNAL_SIZE - 1);
    localparam logic [POS_BITS-1:0]     LAST_POS   = POS_BITS'(IFM_SIZE - 1);
    localparam logic [CH_BITS-1:0]      LAST_CH    = CH_BITS'(IFM_DEPTH - 1);
    localparam logic [ADDRESS_BITS-1:0] CH_STRIDE  = ADDRESS_BITS'(IFM_SIZE * IFM_SIZE);
    localparam logic [ADDRESS_BITS-1:0] ROW_STRIDE = ADDRESS_BITS'(IFM_SIZE);

    if (IFM_DEPTH * IFM_SIZE * IFM_SIZE > (1 << ADDRESS_BITS)) begin : g_addr_width_check
        $error("ADDRESS_BITS too narrow for the last IFM address");
    end
    if (KERNAL_SIZE > IFM_SIZE) begin : g_kernel_check
        $error("KERNAL_SIZE larger than IFM_SIZE");
    end

    state_t state_q, state_d;
    logic   tail_q;
    logic   rd_en;
    logic   clear;

    logic [POS_BITS-1:0] col, row;
    logic [CH_BITS-1:0]  ch;
    logic                frame_last;

    // Position of the pixel currently being pushed into the line buffer.
    logic                fifo_q;
    logic [POS_BITS-1:0] s1_col, s1_row;
    logic [CH_BITS-1:0]  s1_ch;

    logic                             win_vld_q;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] win_addr_q;
    logic [CH_BITS-1:0]               win_ch_q;
    logic                             last_q;
    logic                             done_q;

    logic qualify;
    logic first_win;

    conv_pos_counter #(
        .SIZE     (IFM_SIZE),
        .DEPTH    (IFM_DEPTH),
        .POS_BITS (POS_BITS),
        .CH_BITS  (CH_BITS)
    ) u_rd_pos (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .advance    (rd_en),
        .col        (col),
        .row        (row),
        .ch         (ch),
        .frame_last (frame_last)
    );

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = STREAM;
                    clear   = 1'b1;
                end
            end
            STREAM: begin
                rd_en = !bus.pause;
                if (rd_en && frame_last) state_d = TAIL;
            end
            TAIL: begin
                if (tail_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Two TAIL cycles cover the fifo_enable and window_valid stages of the last read.
            tail_q  <= (state_q == TAIL) ? ~tail_q : 1'b0;
        end
    end

    // Rows above K-1 would combine taps from the previous channel, so they never qualify.
    assign qualify   = fifo_q && (s1_row >= K_M1) && (s1_col >= K_M1);
    assign first_win = (s1_row == K_M1) && (s1_col == K_M1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q     <= 1'b0;
            s1_col     <= '0;
            s1_row     <= '0;
            s1_ch      <= '0;
            win_vld_q  <= 1'b0;
            win_addr_q <= '0;
            win_ch_q   <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            fifo_q <= rd_en;
            if (rd_en) begin
                s1_col <= col;
                s1_row <= row;
                s1_ch  <= ch;
            end
            win_vld_q <= qualify;
            last_q    <= qualify && (s1_ch == LAST_CH) && (s1_row == LAST_POS) && (s1_col == LAST_POS);
            if (fifo_q) win_ch_q <= s1_ch;
            if (qualify) win_addr_q <= first_win ? '0 : win_addr_q + 1'b1;
            done_q <= last_q;
        end
    end

    assign bus.ifm_rd_en    = rd_en;
    assign bus.ifm_rd_addr  = ADDRESS_BITS'(ch) * CH_STRIDE + ADDRESS_BITS'(row) * ROW_STRIDE
                            + ADDRESS_BITS'(col);
    assign bus.fifo_enable  = fifo_q;
    assign bus.window_valid = win_vld_q;
    assign bus.window_addr  = win_addr_q;
    assign bus.window_ch    = win_ch_q;
    assign bus.last_window  = last_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
endmodule
